cpu_wb_arbiter: RTL

Two-requester Wishbone bus arbiter for the mox125 core. It shares the single external Wishbone master port between the instruction fetch unit and the data-memory stage, which issues the loads and stores whose addresses and data come from the execute stage. Data accesses win by fixed priority, with a starvation guard for fetch. Each tenure is held until the owner drops its cycle, and a bus-timeout watchdog returns an error instead of hanging the pipeline.

---
 rtl/cpu_wb_arbiter_pkg.sv | 36 +++
 rtl/cpu_wb_arbiter_if.sv | 43 ++++
 rtl/cpu_wb_watchdog.sv | 42 ++++
 rtl/cpu_wb_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/cpu_wb_arbiter_pkg.sv
// Shared types and constants for the mox125 Wishbone arbiter.
//   ARB_STATE_*   : arbiter state encoding
//   wb_req_t      : master-side request payload (cyc/stb/we/sel/adr/dat)
//   *_DFLT        : default watchdog and starvation limits
package cpu_wb_arbiter_pkg;

  localparam int unsigned ADR_W    = 32;
  localparam int unsigned DAT_W    = 32;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned STARVE_W = 4;
  localparam int unsigned TMO_W    = 8;

  localparam int unsigned TIMEOUT_CYCLES_DFLT = 255;
  localparam int unsigned STARVE_LIMIT_DFLT   = 4;

  typedef enum logic [1:0] {
    ARB_STATE_IDLE    = 2'b00,
    ARB_STATE_GRANT_D = 2'b01,
    ARB_STATE_GRANT_I = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wb_req_t;

  // Saturating increment for the starvation counter.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (&v) ? v : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/cpu_wb_arbiter_if.sv
// Bundle of every bus signal around the arbiter: data requester (d_*),
// fetch requester (i_*) and the shared external master port (wb_*).
//   slave  : the arbiter's view (requests in, master port out)
//   master : the surrounding core/bus view (requests out, master port in)
interface cpu_wb_arbiter_if;
  import cpu_wb_arbiter_pkg::*;

  logic             d_cyc_i, d_stb_i, d_we_i;
  logic [SEL_W-1:0] d_sel_i;
  logic [ADR_W-1:0] d_adr_i;
  logic [DAT_W-1:0] d_dat_i, d_dat_o;
  logic             d_ack_o, d_err_o;

  logic             i_cyc_i, i_stb_i;
  logic [ADR_W-1:0] i_adr_i;
  logic [DAT_W-1:0] i_dat_o;
  logic             i_ack_o, i_err_o;

  logic             wb_cyc_o, wb_stb_o, wb_we_o;
  logic [SEL_W-1:0] wb_sel_o;
  logic [ADR_W-1:0] wb_adr_o;
  logic [DAT_W-1:0] wb_dat_o, wb_dat_i;
  logic             wb_ack_i, wb_err_i;

  modport slave (
    input  d_cyc_i, d_stb_i, d_we_i, d_sel_i, d_adr_i, d_dat_i,
    output d_dat_o, d_ack_o, d_err_o,
    input  i_cyc_i, i_stb_i, i_adr_i,
    output i_dat_o, i_ack_o, i_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport master (
    output d_cyc_i, d_stb_i, d_we_i, d_sel_i, d_adr_i, d_dat_i,
    input  d_dat_o, d_ack_o, d_err_o,
    output i_cyc_i, i_stb_i, i_adr_i,
    input  i_dat_o, i_ack_o, i_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/cpu_wb_watchdog.sv
// Bus-timeout watchdog: counts stalled strobe cycles and flags an abort when
// the count reaches LIMIT.
//   clk_i, rst_i : clock, async active-high reset
//   stall_i      : strobe high with no ack/err this cycle
//   resp_i       : ack or err this cycle (a real response wins over expiry)
//   chg_i        : arbiter state is changing this cycle
//   expire_o     : abort this cycle (combinational)
module cpu_wb_watchdog
  import cpu_wb_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DFLT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  logic resp_i,
  input  logic chg_i,
  output logic expire_o
);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Expiry, then clear on any response, state change or expiry.
  always_comb begin
    expire_o  = (tmo_cnt_q == TMO_W'(LIMIT)) & ~resp_i;
    tmo_cnt_d = tmo_cnt_q;
    if (expire_o | resp_i | chg_i) begin
      tmo_cnt_d = '0;
    end else if (stall_i) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: rtl/cpu_wb_arbiter.sv
// Two-requester Wishbone arbiter: data stage wins by fixed priority, fetch is
// forced through after STARVE_LIMIT consecutive contested data grants. Each
// tenure lasts until the owner drops cyc; a watchdog aborts stalled accesses.
//   clk_i, rst_i : clock, async active-high reset
//   bus          : all d_*/i_*/wb_* signals (slave modport)
//   busy_o       : state is not IDLE
//   timeout_o    : one-cycle pulse on watchdog abort
module cpu_wb_arbiter
  import cpu_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT,
  parameter int unsigned STARVE_LIMIT   = STARVE_LIMIT_DFLT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cpu_wb_arbiter_if.slave        bus,
  output logic                   busy_o,
  output logic                   timeout_o
);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  logic    d_req, i_req;
  logic    expire, stall, resp, chg;
  wb_req_t d_side, i_side, owner;

  assign d_req = bus.d_cyc_i & bus.d_stb_i;
  assign i_req = bus.i_cyc_i & bus.i_stb_i;

  // Candidate master payloads; fetch is a full-word read.
  always_comb begin
    d_side = '{cyc: bus.d_cyc_i, stb: bus.d_stb_i, we: bus.d_we_i,
               sel: bus.d_sel_i, adr: bus.d_adr_i, dat: bus.d_dat_i};
    i_side = '{cyc: bus.i_cyc_i, stb: bus.i_stb_i, we: 1'b0,
               sel: {SEL_W{1'b1}}, adr: bus.i_adr_i, dat: {DAT_W{1'b0}}};
  end

  // Arbitration in IDLE only; a grant is held while the owner keeps cyc.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ARB_STATE_IDLE: begin
        if (d_req && !(i_req && (starve_cnt_q == STARVE_W'(STARVE_LIMIT)))) begin
          state_d = ARB_STATE_GRANT_D;
          if (i_req) begin
            starve_cnt_d = sat_inc(starve_cnt_q);
          end
        end else if (i_req) begin
          state_d      = ARB_STATE_GRANT_I;
          starve_cnt_d = '0;
        end
      end
      ARB_STATE_GRANT_D: if (!bus.d_cyc_i) state_d = ARB_STATE_IDLE;
      ARB_STATE_GRANT_I: if (!bus.i_cyc_i) state_d = ARB_STATE_IDLE;
      default:           state_d = ARB_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_STATE_IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Owner select; all-zero while idle.
  always_comb begin
    owner = '0;
    case (state_q)
      ARB_STATE_GRANT_D: owner = d_side;
      ARB_STATE_GRANT_I: owner = i_side;
      default:           owner = '0;
    endcase
  end

  assign resp  = bus.wb_ack_i | bus.wb_err_i;
  assign stall = owner.stb & ~resp;
  assign chg   = (state_d != state_q);

  cpu_wb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .stall_i  (stall),
    .resp_i   (resp),
    .chg_i    (chg),
    .expire_o (expire)
  );

  // Master port; an abort drops cyc/stb for the expiry cycle.
  assign bus.wb_cyc_o = owner.cyc & ~expire;
  assign bus.wb_stb_o = owner.stb & ~expire;
  assign bus.wb_we_o  = owner.we;
  assign bus.wb_sel_o = owner.sel;
  assign bus.wb_adr_o = owner.adr;
  assign bus.wb_dat_o = owner.dat;

  // Return paths; only the owner sees ack/err.
  assign bus.d_dat_o = bus.wb_dat_i;
  assign bus.i_dat_o = bus.wb_dat_i;
  assign bus.d_ack_o = (state_q == ARB_STATE_GRANT_D) & bus.wb_ack_i;
  assign bus.d_err_o = (state_q == ARB_STATE_GRANT_D) & (bus.wb_err_i | expire);
  assign bus.i_ack_o = (state_q == ARB_STATE_GRANT_I) & bus.wb_ack_i;
  assign bus.i_err_o = (state_q == ARB_STATE_GRANT_I) & (bus.wb_err_i | expire);

  assign busy_o    = (state_q != ARB_STATE_IDLE);
  assign timeout_o = expire;

endmodule
